// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - arbitrated, timed irrigation valve sequencer
//
// Purpose: chooses which valve runs, owns the shared BCD countdown
// (cycle time while watering, rest lockout while idle) and the empty-tank alarm.
// Ports:
//   clock_50MHz, reset_n      clock, async active-low reset
//   one_hz_tick               1 Hz single-cycle strobe
//   sprinkler_req, drip_req   level watering requests (sprinkler wins)
//   specific                  selects SPECIFIC_TIME for drip at cycle start
//   water_box[1:0]            tank level, 00 = empty
//   button                    clean push-button level (edge-detected here)
//   state[1:0]                00 IDLE, 01 SPRINKLER, 10 DRIP, 11 EMPTY
//   valve_sprinkler, valve_drip, alarm   decoded from registered state
//   dozens[1:0], units[3:0]   BCD countdown
//   time_over                 one-cycle pulse on natural cycle completion
module irrigation_scheduler #(
    parameter int SPRINKLER_TIME = 30,
    parameter int DRIP_TIME      = 20,
    parameter int SPECIFIC_TIME  = 15,
    parameter int REST_TIME      = 5
) (
    input  logic       clock_50MHz,
    input  logic       reset_n,
    input  logic       one_hz_tick,
    input  logic       sprinkler_req,
    input  logic       drip_req,
    input  logic       specific,
    input  logic [1:0] water_box,
    input  logic       button,
    output logic [1:0] state,
    output logic       valve_sprinkler,
    output logic       valve_drip,
    output logic [1:0] dozens,
    output logic [3:0] units,
    output logic       time_over,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_SPRINKLER = 2'b01,
        ST_DRIP      = 2'b10,
        ST_EMPTY     = 2'b11
    } state_t;

    // Load values as {dozens, units} BCD, resolved at elaboration.
    localparam logic [5:0] LOAD_SPR  = {2'(SPRINKLER_TIME / 10), 4'(SPRINKLER_TIME % 10)};
    localparam logic [5:0] LOAD_DRIP = {2'(DRIP_TIME / 10),      4'(DRIP_TIME % 10)};
    localparam logic [5:0] LOAD_SPEC = {2'(SPECIFIC_TIME / 10),  4'(SPECIFIC_TIME % 10)};
    localparam logic [5:0] LOAD_REST = {2'(REST_TIME / 10),      4'(REST_TIME % 10)};
    localparam logic [5:0] COUNT_ONE = 6'h01;

    state_t     state_q;
    logic [5:0] count_q;      // {dozens, units}
    logic       time_over_q;
    logic       btn_prev_q;
    logic       btn_edge_q;   // registered rising edge: abort acts one edge later

    function automatic logic [5:0] bcd_dec(input logic [5:0] c);
        logic [5:0] r;
        if (c == 6'h00) begin
            r = c;
        end else if (c[3:0] == 4'd0) begin
            r = {c[5:4] - 2'd1, 4'd9};
        end else begin
            r = {c[5:4], c[3:0] - 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 6'h00;
            time_over_q <= 1'b0;
            btn_prev_q  <= 1'b0;
            btn_edge_q  <= 1'b0;
        end else begin
            btn_prev_q  <= button;
            btn_edge_q  <= button & ~btn_prev_q;
            time_over_q <= 1'b0;

            if (water_box == 2'b00) begin
                // Empty tank overrides everything, including expiry.
                state_q <= ST_EMPTY;
                count_q <= 6'h00;
            end else begin
                unique case (state_q)
                    ST_EMPTY: begin
                        state_q <= ST_IDLE;
                        count_q <= 6'h00;
                    end
                    ST_IDLE: begin
                        if (btn_edge_q) begin
                            count_q <= 6'h00;                 // manual lockout override
                        end else if (count_q != 6'h00) begin
                            if (one_hz_tick) count_q <= bcd_dec(count_q);
                        end else if (sprinkler_req) begin
                            state_q <= ST_SPRINKLER;
                            count_q <= LOAD_SPR;
                        end else if (drip_req) begin
                            state_q <= ST_DRIP;
                            count_q <= specific ? LOAD_SPEC : LOAD_DRIP;
                        end
                    end
                    default: begin                            // SPRINKLER or DRIP
                        if (btn_edge_q) begin
                            state_q <= ST_IDLE;
                            count_q <= LOAD_REST;
                        end else if (one_hz_tick) begin
                            if (count_q == COUNT_ONE) begin
                                state_q     <= ST_IDLE;
                                count_q     <= LOAD_REST;
                                time_over_q <= 1'b1;
                            end else begin
                                count_q <= bcd_dec(count_q);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign state           = state_q;
    assign valve_sprinkler = (state_q == ST_SPRINKLER);
    assign valve_drip      = (state_q == ST_DRIP);
    assign alarm           = (state_q == ST_EMPTY);
    assign dozens          = count_q[5:4];
    assign units           = count_q[3:0];
    assign time_over       = time_over_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb/tb_irrigation_scheduler.sv - directed self-checking bench for irrigation_scheduler
module tb_irrigation_scheduler;

    logic       clock_50MHz = 1'b0;
    logic       reset_n = 1'b0;
    logic       one_hz_tick = 1'b0;
    logic       sprinkler_req = 1'b0;
    logic       drip_req = 1'b0;
    logic       specific = 1'b0;
    logic [1:0] water_box = 2'b11;
    logic       button = 1'b0;
    logic [1:0] state;
    logic       valve_sprinkler;
    logic       valve_drip;
    logic [1:0] dozens;
    logic [3:0] units;
    logic       time_over;
    logic       alarm;

    int checks = 0;
    int errors = 0;
    int to_cnt = 0;
    int to_base;

    irrigation_scheduler dut (
        .clock_50MHz     (clock_50MHz),
        .reset_n         (reset_n),
        .one_hz_tick     (one_hz_tick),
        .sprinkler_req   (sprinkler_req),
        .drip_req        (drip_req),
        .specific        (specific),
        .water_box       (water_box),
        .button          (button),
        .state           (state),
        .valve_sprinkler (valve_sprinkler),
        .valve_drip      (valve_drip),
        .dozens          (dozens),
        .units           (units),
        .time_over       (time_over),
        .alarm           (alarm)
    );

    always #10 clock_50MHz = ~clock_50MHz;

    always @(posedge clock_50MHz) if (time_over === 1'b1) to_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tk);
        one_hz_tick = tk;
        @(posedge clock_50MHz);
        #1;
        one_hz_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    function automatic logic [5:0] cnt();
        return {dozens, units};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clock_50MHz);
        #1;
        check("rst_state", 32'(state), 32'h0);
        check("rst_count", 32'(cnt()), 32'h00);
        check("rst_valves", 32'({valve_sprinkler, valve_drip}), 32'h0);
        check("rst_alarm", 32'(alarm), 32'h0);
        check("rst_time_over", 32'(time_over), 32'h0);
        reset_n = 1'b1;

        // Sprinkler wins over drip, loads 30
        sprinkler_req = 1'b1;
        drip_req      = 1'b1;
        step(1'b0);
        check("spr_start_state", 32'(state), 32'h1);
        check("spr_start_count", 32'(cnt()), 32'h30);
        check("spr_valve", 32'({valve_sprinkler, valve_drip}), 32'h2);
        ticks(1);
        check("spr_wrap_29", 32'(cnt()), 32'h29);
        ticks(28);
        check("spr_count_01", 32'(cnt()), 32'h01);
        check("spr_still_on", 32'(state), 32'h1);
        to_base = to_cnt;
        ticks(1);
        check("spr_expire_state", 32'(state), 32'h0);
        check("spr_expire_pulse", 32'(time_over), 32'h1);
        check("spr_rest_load", 32'(cnt()), 32'h05);
        step(1'b0);
        check("time_over_drop", 32'(time_over), 32'h0);
        check("time_over_once", 32'(to_cnt - to_base), 32'h1);

        // Rest lockout holds off drip for 5 ticks
        sprinkler_req = 1'b0;
        ticks(4);
        check("rest_4_state", 32'(state), 32'h0);
        check("rest_4_count", 32'(cnt()), 32'h01);
        ticks(1);
        check("rest_done_state", 32'(state), 32'h0);
        check("rest_done_count", 32'(cnt()), 32'h00);
        step(1'b0);
        check("drip_start_state", 32'(state), 32'h2);
        check("drip_start_count", 32'(cnt()), 32'h20);
        check("drip_valve", 32'({valve_sprinkler, valve_drip}), 32'h1);

        // BCD wrap in drip
        ticks(1);
        check("drip_wrap_19", 32'(cnt()), 32'h19);
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            check("units_le_9", 32'(units <= 4'd9), 32'h1);
        end
        check("drip_count_09", 32'(cnt()), 32'h09);
        ticks(2);
        check("drip_count_07", 32'(cnt()), 32'h07);

        // Button abort, one edge of latency, no time_over
        to_base = to_cnt;
        button = 1'b1;
        step(1'b0);
        check("abort_latency", 32'(state), 32'h2);
        step(1'b0);
        check("abort_state", 32'(state), 32'h0);
        check("abort_count", 32'(cnt()), 32'h05);
        check("abort_no_to", 32'(time_over), 32'h0);
        drip_req = 1'b0;
        button   = 1'b0;
        step(1'b0);
        check("abort_no_to_cnt", 32'(to_cnt - to_base), 32'h0);

        // Second press in idle clears lockout
        button = 1'b1;
        step(1'b0);
        step(1'b0);
        check("override_count", 32'(cnt()), 32'h00);
        check("override_state", 32'(state), 32'h0);
        button = 1'b0;

        // Specific drip load; dropping requests mid-cycle has no effect
        specific = 1'b1;
        drip_req = 1'b1;
        step(1'b0);
        check("spec_state", 32'(state), 32'h2);
        check("spec_count", 32'(cnt()), 32'h15);
        drip_req = 1'b0;
        specific = 1'b0;
        ticks(3);
        check("req_drop_state", 32'(state), 32'h2);
        check("req_drop_count", 32'(cnt()), 32'h12);

        // Empty tank mid-cycle
        water_box = 2'b00;
        step(1'b0);
        check("empty_state", 32'(state), 32'h3);
        check("empty_alarm", 32'(alarm), 32'h1);
        check("empty_valves", 32'({valve_sprinkler, valve_drip}), 32'h0);
        check("empty_count", 32'(cnt()), 32'h00);
        button = 1'b1;
        step(1'b0);
        step(1'b0);
        check("empty_button_ignored", 32'(state), 32'h3);
        button = 1'b0;
        step(1'b0);
        water_box     = 2'b01;
        sprinkler_req = 1'b1;
        step(1'b0);
        check("refill_state", 32'(state), 32'h0);
        check("refill_count", 32'(cnt()), 32'h00);
        check("refill_alarm", 32'(alarm), 32'h0);
        step(1'b0);
        check("refill_start_state", 32'(state), 32'h1);
        check("refill_start_count", 32'(cnt()), 32'h30);

        // Expiry tick coinciding with empty tank
        ticks(29);
        check("coinc_count_01", 32'(cnt()), 32'h01);
        to_base   = to_cnt;
        water_box = 2'b00;
        ticks(1);
        check("coinc_state", 32'(state), 32'h3);
        check("coinc_no_pulse", 32'(time_over), 32'h0);
        check("coinc_count", 32'(cnt()), 32'h00);
        water_box     = 2'b11;
        sprinkler_req = 1'b0;
        step(1'b0);
        check("coinc_no_to_cnt", 32'(to_cnt - to_base), 32'h0);
        check("coinc_idle", 32'(state), 32'h0);

        // Async reset mid-drip
        drip_req = 1'b1;
        step(1'b0);
        check("pre_reset_state", 32'(state), 32'h2);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'h0);
        check("async_rst_valves", 32'({valve_sprinkler, valve_drip}), 32'h0);
        check("async_rst_count", 32'(cnt()), 32'h00);
        check("async_rst_alarm_to", 32'({alarm, time_over}), 32'h0);
        step(1'b0);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
